// File: rtl/ycbcr_pkg.sv
// Shared constants and helpers for the BT.601 studio-swing YCbCr -> RGB path.
package ycbcr_pkg;

  // Fixed-point coefficients (x256) for the conversion equations
  localparam int COEF_Y   = 298;
  localparam int COEF_RCR = 409;
  localparam int COEF_GCB = 100;
  localparam int COEF_GCR = 208;
  localparam int COEF_BCB = 516;

  // Input offsets, rounding constant and final scaling shift
  localparam int OFF_Y    = 16;
  localparam int OFF_C    = 128;
  localparam int ROUND    = 128;
  localparam int SHIFT    = 8;

  // Pixel and sync latency through the converter
  localparam int PIPE_LAT = 4;

  // Datapath widths: 9-bit offsets, 20-bit products/sums, 12-bit scaled result
  localparam int OFS_W = 9;
  localparam int ACC_W = 20;
  localparam int RES_W = 12;

  typedef logic signed [OFS_W-1:0] ofs_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [RES_W-1:0] res_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  // Sign-extend an offset value to accumulator width
  function automatic acc_t sext(input ofs_t v);
    return acc_t'(v);
  endfunction

  // Saturate a scaled channel result to 0..255
  function automatic logic [7:0] clamp_u8(input res_t v);
    if (v < res_t'(0)) return '0;
    if (v > res_t'(255)) return '1;
    return v[7:0];
  endfunction

  // A channel is clipped when its unclamped value leaves 0..255
  function automatic logic is_clip(input res_t v);
    return (v < res_t'(0)) || (v > res_t'(255));
  endfunction

endpackage

// File: rtl/video_sync_delay.sv
// Resettable fixed-depth delay line for video sync/control bits.
module video_sync_delay #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] tap_q [DEPTH];

  // Shift register; every tap clears on reset so no stale sync survives
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        tap_q[k] <= '0;
      end
    end else begin
      tap_q[0] <= data_i;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        tap_q[k] <= tap_q[k-1];
      end
    end
  end

  assign data_o = tap_q[DEPTH-1];

endmodule

// File: rtl/ycbcr_to_rgb.sv
// BT.601 studio-swing YCbCr to full-range RGB, 4-stage pipeline.
// Optional per-frame clipped-pixel statistics: YCBCR_TO_RGB_CLIP_STAT_EN.
module ycbcr_to_rgb
  import ycbcr_pkg::*;
#(
  parameter int unsigned CLIP_CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_hsyn,
  input  logic                  i_vsyn,
  input  logic                  i_de,
  input  logic [7:0]            i_y,
  input  logic [7:0]            i_cb,
  input  logic [7:0]            i_cr,
  output logic                  o_hs,
  output logic                  o_vs,
  output logic                  o_de,
  output logic [7:0]            o_r,
  output logic [7:0]            o_g,
  output logic [7:0]            o_b,
  output logic [CLIP_CNT_W-1:0] o_clip_cnt,
  output logic                  o_clip_vld
);

  // ---------------- S1: offsets ----------------
  ofs_t yo_d, cbo_d, cro_d;
  ofs_t yo_q, cbo_q, cro_q;

  // Remove studio-swing offsets; results fit 9-bit signed
  always_comb begin
    yo_d  = ofs_t'({1'b0, i_y}  - 9'(OFF_Y));
    cbo_d = ofs_t'({1'b0, i_cb} - 9'(OFF_C));
    cro_d = ofs_t'({1'b0, i_cr} - 9'(OFF_C));
  end

  // S1 registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      yo_q  <= '0;
      cbo_q <= '0;
      cro_q <= '0;
    end else begin
      yo_q  <= yo_d;
      cbo_q <= cbo_d;
      cro_q <= cro_d;
    end
  end

  // ---------------- S2: products ----------------
  acc_t py_d, prcr_d, pgcb_d, pgcr_d, pbcb_d;
  acc_t py_q, prcr_q, pgcb_q, pgcr_q, pbcb_q;

  // Constant multiplies in 20-bit signed arithmetic
  always_comb begin
    py_d   = sext(yo_q)  * acc_t'(COEF_Y);
    prcr_d = sext(cro_q) * acc_t'(COEF_RCR);
    pgcb_d = sext(cbo_q) * acc_t'(COEF_GCB);
    pgcr_d = sext(cro_q) * acc_t'(COEF_GCR);
    pbcb_d = sext(cbo_q) * acc_t'(COEF_BCB);
  end

  // S2 registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      py_q   <= '0;
      prcr_q <= '0;
      pgcb_q <= '0;
      pgcr_q <= '0;
      pbcb_q <= '0;
    end else begin
      py_q   <= py_d;
      prcr_q <= prcr_d;
      pgcb_q <= pgcb_d;
      pgcr_q <= pgcr_d;
      pbcb_q <= pbcb_d;
    end
  end

  // ---------------- S3: sums plus rounding ----------------
  res_t rs_d, gs_d, bs_d;
  res_t rs_q, gs_q, bs_q;

  // Sum, round and scale; the scaled value (-277..534) fits 12-bit signed
  always_comb begin
    rs_d = res_t'((py_q + prcr_q + acc_t'(ROUND)) >>> SHIFT);
    gs_d = res_t'((py_q - pgcb_q - pgcr_q + acc_t'(ROUND)) >>> SHIFT);
    bs_d = res_t'((py_q + pbcb_q + acc_t'(ROUND)) >>> SHIFT);
  end

  // S3 registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rs_q <= '0;
      gs_q <= '0;
      bs_q <= '0;
    end else begin
      rs_q <= rs_d;
      gs_q <= gs_d;
      bs_q <= bs_d;
    end
  end

  // ---------------- S4: clamp into output registers ----------------
  logic [7:0] r_d, g_d, b_d;
  logic [7:0] r_q, g_q, b_q;

  // Saturate each channel to 8 bits
  always_comb begin
    r_d = clamp_u8(rs_q);
    g_d = clamp_u8(gs_q);
    b_d = clamp_u8(bs_q);
  end

  // S4 registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  // ---------------- Sync alignment ----------------
  sync_t sync_in, sync_out;

  assign sync_in = '{hs: i_hsyn, vs: i_vsyn, de: i_de};

  video_sync_delay #(
    .WIDTH($bits(sync_t)),
    .DEPTH(PIPE_LAT)
  ) u_sync_delay (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .data_i(sync_in),
    .data_o(sync_out)
  );

  assign o_hs = sync_out.hs;
  assign o_vs = sync_out.vs;
  assign o_de = sync_out.de;

  // Pixels run through the pipe regardless of de; blanking is applied at the output
  assign o_r = sync_out.de ? r_q : '0;
  assign o_g = sync_out.de ? g_q : '0;
  assign o_b = sync_out.de ? b_q : '0;

`ifdef YCBCR_TO_RGB_CLIP_STAT_EN
  // ---------------- Clip statistics ----------------
  logic                  clip_d, clip_q;
  logic                  vs_prev_q;
  logic                  seen_d, seen_q;
  logic                  vld_d, vld_q;
  logic [CLIP_CNT_W-1:0] cnt_d, cnt_q;
  logic [CLIP_CNT_W-1:0] out_d, out_q;
  logic                  vs_rise;
  logic                  hit;

  // Any channel out of range; registered alongside S4 so it lines up with o_de
  always_comb begin
    clip_d = is_clip(rs_q) | is_clip(gs_q) | is_clip(bs_q);
  end

  assign vs_rise = o_vs & ~vs_prev_q;
  assign hit     = o_de & clip_q;

  // Frame accounting: the first vs rise after reset closes a partial frame and
  // is not reported; a clipped pixel on the rise cycle opens the new count
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    vld_d  = 1'b0;
    seen_d = seen_q;
    if (vs_rise) begin
      if (seen_q) begin
        out_d = cnt_q;
        vld_d = 1'b1;
      end else begin
        seen_d = 1'b1;
      end
      cnt_d = hit ? CLIP_CNT_W'(1) : '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CLIP_CNT_W'(1);
    end
  end

  // Clip statistics registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clip_q    <= 1'b0;
      vs_prev_q <= 1'b0;
      seen_q    <= 1'b0;
      vld_q     <= 1'b0;
      cnt_q     <= '0;
      out_q     <= '0;
    end else begin
      clip_q    <= clip_d;
      vs_prev_q <= o_vs;
      seen_q    <= seen_d;
      vld_q     <= vld_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
    end
  end

  assign o_clip_cnt = out_q;
  assign o_clip_vld = vld_q;
`else
  assign o_clip_cnt = '0;
  assign o_clip_vld = 1'b0;
`endif

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Self-checking bench for ycbcr_to_rgb; honours YCBCR_TO_RGB_CLIP_STAT_EN.
module tb_ycbcr_to_rgb;

  localparam int unsigned CW   = 16;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          hsyn, vsyn, de;
  logic [7:0]    y, cb, cr;
  logic          hs_o, vs_o, de_o;
  logic [7:0]    r_o, g_o, b_o;
  logic [CW-1:0] clip_cnt_o;
  logic          clip_vld_o;

  ycbcr_to_rgb #(.CLIP_CNT_W(CW)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_hsyn    (hsyn),
    .i_vsyn    (vsyn),
    .i_de      (de),
    .i_y       (y),
    .i_cb      (cb),
    .i_cr      (cr),
    .o_hs      (hs_o),
    .o_vs      (vs_o),
    .o_de      (de_o),
    .o_r       (r_o),
    .o_g       (g_o),
    .o_b       (b_o),
    .o_clip_cnt(clip_cnt_o),
    .o_clip_vld(clip_vld_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit hs;
    bit vs;
    bit de;
    int y;
    int cb;
    int cr;
    int id;
  } pix_t;

  pix_t hist[$];
  int   checks = 0;
  int   errors = 0;

  // Hard-coded results for the directed vectors (index = vector id)
  int dir_r [5] = '{0, 0, 255, 255, 255};
  int dir_g [5] = '{0, 0, 255, 0,   125};
  int dir_b [5] = '{0, 0, 255, 0,   255};

  // Frame-statistics reference state
  int m_cnt = 0;
  int m_out = 0;
  bit m_vld = 0;
  bit m_seen = 0;
  bit p_vs = 0;
  bit pp_vs = 0;
  bit p_hit = 0;
  int vld_cnts[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Reference conversion straight from the equations, in plain integers
  function automatic void ref_rgb(input pix_t p, output int r, output int g,
                                  output int b, output bit clip);
    int yo, cbo, cro, rr, gg, bb;
    yo   = p.y - 16;
    cbo  = p.cb - 128;
    cro  = p.cr - 128;
    rr   = (298 * yo + 409 * cro + 128) >>> 8;
    gg   = (298 * yo - 100 * cbo - 208 * cro + 128) >>> 8;
    bb   = (298 * yo + 516 * cbo + 128) >>> 8;
    clip = (rr < 0) || (rr > 255) || (gg < 0) || (gg > 255) || (bb < 0) || (bb > 255);
    r    = p.de ? clamp(rr) : 0;
    g    = p.de ? clamp(gg) : 0;
    b    = p.de ? clamp(bb) : 0;
  endfunction

  task automatic reset_hist();
    pix_t z;
    z = '{default: 0};
    hist.delete();
    repeat (4) hist.push_back(z);
  endtask

  // Drive one pixel, advance one clock, compare outputs with the reference
  task automatic cycle(input bit h, input bit v, input bit d,
                       input int yy, input int bb_in, input int rr_in, input int id);
    pix_t p, e;
    int   er, eg, eb;
    bit   clip, rise;
    hsyn = h;
    vsyn = v;
    de   = d;
    y    = 8'(yy);
    cb   = 8'(bb_in);
    cr   = 8'(rr_in);
    p    = '{h, v, d, yy, bb_in, rr_in, id};
    @(posedge clk);
    if (rst_n) begin
      hist.push_back(p);
      void'(hist.pop_front());
    end else begin
      reset_hist();
    end
    #1;
    e = hist[0];
    ref_rgb(e, er, eg, eb, clip);
    check_val("de", 32'(de_o), 32'(e.de));
    check_val("hs", 32'(hs_o), 32'(e.hs));
    check_val("vs", 32'(vs_o), 32'(e.vs));
    check_val("r",  32'(r_o),  er);
    check_val("g",  32'(g_o),  eg);
    check_val("b",  32'(b_o),  eb);
    if (e.id != 0) begin
      check_val("dir_r", 32'(r_o), dir_r[e.id]);
      check_val("dir_g", 32'(g_o), dir_g[e.id]);
      check_val("dir_b", 32'(b_o), dir_b[e.id]);
    end
`ifdef YCBCR_TO_RGB_CLIP_STAT_EN
    if (!rst_n) begin
      m_cnt = 0; m_out = 0; m_vld = 0; m_seen = 0;
      p_vs = 0; pp_vs = 0; p_hit = 0;
    end else begin
      rise = p_vs && !pp_vs;
      if (rise) begin
        if (m_seen) begin
          m_out = m_cnt;
          m_vld = 1;
        end else begin
          m_seen = 1;
          m_vld  = 0;
        end
        m_cnt = p_hit ? 1 : 0;
      end else begin
        m_vld = 0;
        if (p_hit && m_cnt < MAXC) m_cnt++;
      end
      pp_vs = p_vs;
      p_vs  = e.vs;
      p_hit = e.de && clip;
    end
    check_val("clip_cnt", 32'(clip_cnt_o), m_out);
    check_val("clip_vld", 32'(clip_vld_o), 32'(m_vld));
    if (clip_vld_o === 1'b1) vld_cnts.push_back(int'(clip_cnt_o));
`else
    check_val("clip_cnt_off", 32'(clip_cnt_o), 0);
    check_val("clip_vld_off", 32'(clip_vld_o), 0);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 16, 128, 128, 0);
  endtask

  // 5 lines x 20 pixels; the directed variant has exactly 37 clipping pixels
  task automatic frame(input bit directed);
    int px;
    px = 0;
    repeat (2) cycle(0, 1, 0, 16, 128, 128, 0);
    idle(1);
    for (int ln = 0; ln < 5; ln++) begin
      repeat (2) cycle(1, 0, 0, 16, 128, 128, 0);
      for (int col = 0; col < 20; col++) begin
        if (directed) begin
          if (px < 37) cycle(0, 0, 1, 255, 255, 255, 0);
          else         cycle(0, 0, 1, 128, 128, 128, 0);
        end else begin
          cycle(0, 0, 1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), 0);
        end
        px++;
      end
      idle(2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    hsyn = 0; vsyn = 0; de = 0; y = 0; cb = 0; cr = 0;
    reset_hist();
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Directed conversion vectors back to back
    cycle(0, 0, 1, 16,  128, 128, 1);
    cycle(0, 0, 1, 235, 128, 128, 2);
    cycle(0, 0, 1, 81,  90,  240, 3);
    cycle(0, 0, 1, 255, 255, 255, 4);
    idle(6);

    // Random streaming with de low, pipe must still convert
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, int'($urandom_range(0, 1)) == 1, int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0);
    end

    // Frames: partial-first, 37-of-100 directed, then random
    frame(0);
    frame(1);
    frame(0);
    frame(0);
    repeat (2) cycle(0, 1, 0, 16, 128, 128, 0);
    idle(8);
`ifdef YCBCR_TO_RGB_CLIP_STAT_EN
    check_val("vld_events", vld_cnts.size(), 4);
    if (vld_cnts.size() >= 2) check_val("frame37", vld_cnts[1], 37);
    else check_val("frame37_missing", 0, 1);
`endif

    // Syncs toggling every cycle with a reset pulse mid-line
    for (int i = 0; i < 30; i++) begin
      rst_n = !(i >= 12 && i < 15);
      cycle(i % 2 == 1, i % 2 == 0, i % 2 == 1, int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0);
    end
    rst_n = 1'b1;
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
